// File: rtl/cpu_accel_pkg.sv
// Shared types for the accelerator request queue: request op, queued
// request record, queue FSM states and a saturating counter helper.
package cpu_accel_pkg;

  localparam int ACC_ADDR_W = 16;
  localparam int ACC_DATA_W = 32;

  typedef enum logic {
    ACC_RD = 1'b0,
    ACC_WR = 1'b1
  } accel_op_e;

  typedef struct packed {
    accel_op_e               op;
    logic [ACC_ADDR_W-1:0]   addr;
    logic [ACC_DATA_W-1:0]   wdata;
  } accel_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } memq_state_e;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_accel_memq_fifo.sv
// Synchronous request FIFO. Pointers carry one wrap bit beyond the index so
// that full and empty are told apart by pointer equality plus the wrap bit.
module cpu_accel_memq_fifo
  import cpu_accel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  accel_req_t             data_i,
  input  logic                   pop_i,
  output accel_req_t             data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  accel_req_t       mem_q [DEPTH];
  logic [PTR_W:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W:0]   rdPtr_q, rdPtr_d;
  logic             doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign wrPtr_d = wrPtr_q + (PTR_W+1)'(doPush);
  assign rdPtr_d = rdPtr_q + (PTR_W+1)'(doPop);
  assign count_o = wrPtr_q - rdPtr_q;
  assign data_o  = mem_q[rdPtr_q[PTR_W-1:0]];

  // Advance read/write pointers; reset discards every stored entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/cpu_accel_memq.sv
// Accelerator request queue in front of the data-memory arbiter accel port.
// Requests are buffered, issued one at a time, reissued when the arbiter
// drops them, and completed as a held read response or a write-ack pulse.
module cpu_accel_memq
  import cpu_accel_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int DATA_W = ACC_DATA_W,
  parameter int RD_W   = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_wr_i,
  input  logic [ADDR_W-1:0]      req_addr_i,
  input  logic [DATA_W-1:0]      req_wdata_i,
  output logic [ADDR_W-1:0]      accel_addr_o,
  output logic [DATA_W-1:0]      accel_wrt_data_o,
  output logic                   accel_wrt_en_o,
  output logic                   accel_rd_en_o,
  input  logic                   accel_wrt_done_i,
  input  logic                   accel_rd_valid_i,
  input  logic [RD_W-1:0]        accel_rd_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [RD_W-1:0]        rsp_data_o,
  output logic                   wr_ack_o,
  output logic [$clog2(DEPTH):0] q_count_o,
  output logic [15:0]            retry_cnt_o
);

  // ADDR_W and DATA_W must match the field widths of accel_req_t.
  accel_req_t   reqIn, head;
  logic         fifoFull, fifoEmpty, pop, matched, issuing;
  memq_state_e  state_q, state_d;
  logic         rspValid_q, rspValid_d;
  logic [RD_W-1:0] rspData_q, rspData_d;
  logic         wrAck_q, wrAck_d;
  logic [15:0]  retryCnt_q, retryCnt_d;

  assign reqIn = '{op: (req_wr_i ? ACC_WR : ACC_RD), addr: req_addr_i, wdata: req_wdata_i};

  cpu_accel_memq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_valid_i),
    .data_i  (reqIn),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (q_count_o)
  );

  assign issuing          = (state_q == ISSUE);
  assign accel_addr_o     = issuing ? head.addr  : '0;
  assign accel_wrt_data_o = issuing ? head.wdata : '0;
  assign accel_wrt_en_o   = issuing && (head.op == ACC_WR);
  assign accel_rd_en_o    = issuing && (head.op == ACC_RD);
  assign req_ready_o      = !fifoFull;
  assign rsp_valid_o      = rspValid_q;
  assign rsp_data_o       = rspData_q;
  assign wr_ack_o         = wrAck_q;
  assign retry_cnt_o      = retryCnt_q;

  // Issue FSM: a read waits in IDLE while the response slot is occupied, so a
  // new read completion can never collide with a response still being held.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    matched    = 1'b0;
    rspValid_d = rspValid_q && !rsp_ready_i;
    rspData_d  = rspData_q;
    wrAck_d    = 1'b0;
    retryCnt_d = retryCnt_q;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty && !((head.op == ACC_RD) && rspValid_q)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        matched = (head.op == ACC_WR) ? accel_wrt_done_i : accel_rd_valid_i;
        if (matched) begin
          pop     = 1'b1;
          state_d = IDLE;
          if (head.op == ACC_RD) begin
            rspValid_d = 1'b1;
            rspData_d  = accel_rd_data_i;
          end else begin
            wrAck_d = 1'b1;
          end
        end else begin
          retryCnt_d = satInc16(retryCnt_q);
          state_d    = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, response, ack and retry registers; reset abandons any in-flight access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      wrAck_q    <= 1'b0;
      retryCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      wrAck_q    <= wrAck_d;
      retryCnt_q <= retryCnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_accel_memq.sv
// Bench for cpu_accel_memq: a behavioural arbiter with programmable drops,
// a push-order log and a memory-line function form the reference.
module tb_cpu_accel_memq;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [31:0] data;
   } txn_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_wr;
   logic [15:0]  req_addr;
   logic [31:0]  req_wdata;
   logic [15:0]  accel_addr;
   logic [31:0]  accel_wrt_data;
   logic         accel_wrt_en, accel_rd_en, accel_wrt_done, accel_rd_valid;
   logic [511:0] accel_rd_data;
   logic         rsp_valid, rsp_ready;
   logic [511:0] rsp_data;
   logic         wr_ack;
   logic [3:0]   q_count;
   logic [15:0]  retry_cnt;

   txn_t         pushLog[$];
   txn_t         grantLog[$];
   logic [511:0] rspLog[$];
   int tests = 0, failed = 0;
   int drops = 0, dropBudget = 0, ackCnt = 0, protoErrs = 0, timeouts = 0;
   bit lastWr = 0, lastRd = 0, randRsp = 0;
   logic [15:0] lastAddr = '0;
   logic [31:0] lastData = '0;

   cpu_accel_memq #(.DEPTH(8), .ADDR_W(16), .DATA_W(32), .RD_W(512)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .accel_addr_o(accel_addr), .accel_wrt_data_o(accel_wrt_data),
      .accel_wrt_en_o(accel_wrt_en), .accel_rd_en_o(accel_rd_en),
      .accel_wrt_done_i(accel_wrt_done), .accel_rd_valid_i(accel_rd_valid),
      .accel_rd_data_i(accel_rd_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
      .wr_ack_o(wr_ack), .q_count_o(q_count), .retry_cnt_o(retry_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected completion");
      $fatal(1);
   end

   // Memory content the arbiter returns for a line address
   function automatic logic [511:0] memLine(input logic [15:0] a);
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = {a, a ^ 16'(i * 4951)};
      return l;
   endfunction

   function automatic int orderErrors();
      int e = (pushLog.size() != grantLog.size()) ? 1 : 0;
      for (int i = 0; i < pushLog.size() && i < grantLog.size(); i++)
         if (pushLog[i].wr != grantLog[i].wr || pushLog[i].addr !== grantLog[i].addr ||
             pushLog[i].data !== grantLog[i].data) e++;
      return e;
   endfunction

   function automatic int rspErrors();
      logic [511:0] expQ[$];
      int e = 0;
      foreach (pushLog[i]) if (!pushLog[i].wr) expQ.push_back(memLine(pushLog[i].addr));
      if (expQ.size() != rspLog.size()) e++;
      for (int i = 0; i < expQ.size() && i < rspLog.size(); i++) if (expQ[i] !== rspLog[i]) e++;
      return e;
   endfunction

   function automatic int writeCount();
      int n = 0;
      foreach (pushLog[i]) if (pushLog[i].wr) n++;
      return n;
   endfunction

   task automatic clear_logs();
      pushLog.delete(); grantLog.delete(); rspLog.delete();
      ackCnt = 0; protoErrs = 0;
   endtask

   // One clock: log a response take, then at the falling edge play the arbiter
   task automatic tick();
      bit gWr, gRd;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) rspLog.push_back(rsp_data);
      @(posedge clk);
      @(negedge clk);
      gWr = 0; gRd = 0;
      if (lastWr || lastRd) begin
         if (dropBudget > 0) begin
            dropBudget--; drops++;
         end else begin
            gWr = lastWr; gRd = lastRd;
            grantLog.push_back('{wr: lastWr, addr: lastAddr, data: (lastWr ? lastData : 32'h0)});
         end
      end
      accel_wrt_done = gWr;
      accel_rd_valid = gRd;
      accel_rd_data  = gRd ? memLine(lastAddr) : {16{32'($urandom())}};
      if (wr_ack === 1'b1) ackCnt++;
      if ((accel_wrt_en || accel_rd_en) && (lastWr || lastRd)) protoErrs++;
      if (accel_wrt_en && accel_rd_en) protoErrs++;
      if (!accel_wrt_en && !accel_rd_en && (accel_addr !== 16'h0 || accel_wrt_data !== 32'h0)) protoErrs++;
      if (accel_rd_en && rsp_valid) protoErrs++;
      lastWr = accel_wrt_en; lastRd = accel_rd_en;
      lastAddr = accel_addr; lastData = accel_wrt_data;
   endtask

   task automatic push_req(input bit wr, input logic [15:0] a, input logic [31:0] d);
      int n = 0;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
      while (!req_ready && n < 500) begin
         if (randRsp) rsp_ready = 1'($urandom_range(0, 1));
         tick(); n++;
      end
      if (!req_ready) begin
         timeouts++; req_valid = 1'b0;
         return;
      end
      pushLog.push_back('{wr: wr, addr: a, data: (wr ? d : 32'h0)});
      tick();
   endtask

   task automatic drain();
      int n = 0, quiet = 0;
      req_valid = 1'b0; rsp_ready = 1'b1;
      while (n < 3000 && quiet < 6) begin
         tick(); n++;
         if (q_count == 0 && !rsp_valid && !accel_wrt_en && !accel_rd_en && !wr_ack) quiet++;
         else quiet = 0;
      end
      if (quiet < 6) timeouts++;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
      accel_wrt_done = 0; accel_rd_valid = 0; accel_rd_data = '0;
      repeat (2) tick();
      rst = 1'b0;
      drops = 0; dropBudget = 0; clear_logs();
      tests++; if (req_ready !== 1'b1) begin failed++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
      tests++; if (q_count !== 4'd0) begin failed++; $display("[TB] FAIL reset_qcount: got %0d expected 0", q_count); end
      tests++; if ({rsp_valid, wr_ack, accel_wrt_en, accel_rd_en} !== 4'b0) begin failed++; $display("[TB] FAIL reset_flags: got %b expected 0000", {rsp_valid, wr_ack, accel_wrt_en, accel_rd_en}); end
      tests++; if (rsp_data !== 512'h0) begin failed++; $display("[TB] FAIL reset_rspdata: got %h expected 0", rsp_data); end
      tests++; if ({retry_cnt, accel_addr, accel_wrt_data} !== 64'h0) begin failed++; $display("[TB] FAIL reset_busses: got %h expected 0", {retry_cnt, accel_addr, accel_wrt_data}); end
   endtask

   task automatic test_single_write();
      push_req(1'b1, 16'h0010, 32'hDEADBEEF);
      req_valid = 1'b0;
      tests++; if (q_count !== 4'd1 || accel_wrt_en !== 1'b0) begin failed++; $display("[TB] FAIL wr_after_push: got q=%0d en=%b expected q=1 en=0", q_count, accel_wrt_en); end
      tick();
      tests++; if ({accel_wrt_en, accel_rd_en} !== 2'b10) begin failed++; $display("[TB] FAIL wr_issue_en: got %b expected 10", {accel_wrt_en, accel_rd_en}); end
      tests++; if (accel_addr !== 16'h0010 || accel_wrt_data !== 32'hDEADBEEF) begin failed++; $display("[TB] FAIL wr_issue_bus: got %h/%h expected 0010/deadbeef", accel_addr, accel_wrt_data); end
      tick();
      tests++; if (accel_wrt_en !== 1'b0) begin failed++; $display("[TB] FAIL wr_en_one_cycle: got %b expected 0", accel_wrt_en); end
      tick();
      tests++; if (wr_ack !== 1'b1 || q_count !== 4'd0) begin failed++; $display("[TB] FAIL wr_ack_pulse: got ack=%b q=%0d expected ack=1 q=0", wr_ack, q_count); end
      tick();
      tests++; if (wr_ack !== 1'b0) begin failed++; $display("[TB] FAIL wr_ack_single: got %b expected 0", wr_ack); end
      drain();
      tests++; if (orderErrors() != 0 || protoErrs != 0) begin failed++; $display("[TB] FAIL wr_log: got order_err=%0d proto_err=%0d expected 0/0", orderErrors(), protoErrs); end
      clear_logs();
   endtask

   task automatic test_read_retry();
      int n = 0;
      dropBudget = 3; rsp_ready = 1'b0;
      push_req(1'b0, 16'h0020, 32'($urandom()));
      req_valid = 1'b0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      tests++; if (rsp_valid !== 1'b1) begin failed++; $display("[TB] FAIL rd_rsp_timeout: got %b expected 1", rsp_valid); end
      tests++; if (retry_cnt !== 16'd3) begin failed++; $display("[TB] FAIL rd_retry_cnt: got %0d expected 3", retry_cnt); end
      tests++; if (rsp_data !== memLine(16'h0020)) begin failed++; $display("[TB] FAIL rd_rsp_data: got %h expected %h", rsp_data, memLine(16'h0020)); end
      rsp_ready = 1'b1;
      tick();
      tests++; if (rsp_valid !== 1'b0 || q_count !== 4'd0) begin failed++; $display("[TB] FAIL rd_rsp_taken: got v=%b q=%0d expected v=0 q=0", rsp_valid, q_count); end
      drain();
      tests++; if (orderErrors() != 0 || rspErrors() != 0 || protoErrs != 0) begin failed++; $display("[TB] FAIL rd_log: got %0d/%0d/%0d expected 0/0/0", orderErrors(), rspErrors(), protoErrs); end
      clear_logs();
   endtask

   task automatic test_back_to_back();
      int held = 0;
      dropBudget = 1000000; rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) push_req(1'b1, 16'(16'h0100 + i * 4), 32'($urandom()));
      tests++; if (q_count !== 4'd8 || req_ready !== 1'b0) begin failed++; $display("[TB] FAIL b2b_full: got q=%0d ready=%b expected q=8 ready=0", q_count, req_ready); end
      req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0120; req_wdata = 32'h12345678;
      repeat (3) begin tick(); if (req_ready !== 1'b0 || q_count !== 4'd8) held++; end
      tests++; if (held != 0) begin failed++; $display("[TB] FAIL b2b_hold: got %0d ready cycles expected 0", held); end
      dropBudget = 0;
      push_req(1'b1, 16'h0120, 32'h12345678);
      req_valid = 1'b0;
      tests++; if (ackCnt != 1 || q_count !== 4'd8) begin failed++; $display("[TB] FAIL b2b_ninth: got acks=%0d q=%0d expected acks=1 q=8", ackCnt, q_count); end
      drain();
      tests++; if (orderErrors() != 0 || ackCnt != 9) begin failed++; $display("[TB] FAIL b2b_order: got order_err=%0d acks=%0d expected 0/9", orderErrors(), ackCnt); end
      tests++; if (retry_cnt !== 16'(drops) || protoErrs != 0) begin failed++; $display("[TB] FAIL b2b_retry: got %0d proto=%0d expected %0d proto=0", retry_cnt, protoErrs, drops); end
      clear_logs();
   endtask

   task automatic test_rsp_gate();
      int n = 0;
      dropBudget = 0; rsp_ready = 1'b0;
      push_req(1'b0, 16'h0300, 32'h0);
      push_req(1'b0, 16'h0304, 32'h0);
      req_valid = 1'b0;
      repeat (20) tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== memLine(16'h0300)) begin failed++; $display("[TB] FAIL gate_first: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, memLine(16'h0300)); end
      tests++; if (grantLog.size() != 1 || q_count !== 4'd1) begin failed++; $display("[TB] FAIL gate_second_held: got grants=%0d q=%0d expected 1/1", grantLog.size(), q_count); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== memLine(16'h0304)) begin failed++; $display("[TB] FAIL gate_second: got v=%b d=%h expected v=1 d=%h", rsp_valid, rsp_data, memLine(16'h0304)); end
      drain();
      tests++; if (rspErrors() != 0 || orderErrors() != 0 || protoErrs != 0) begin failed++; $display("[TB] FAIL gate_log: got %0d/%0d/%0d expected 0/0/0", rspErrors(), orderErrors(), protoErrs); end
      clear_logs();
   endtask

   task automatic test_reset_mid();
      int n = 0, activity = 0;
      dropBudget = 0; rsp_ready = 1'b1;
      push_req(1'b0, 16'h0400, 32'h0);
      push_req(1'b1, 16'h0404, 32'hCAFEF00D);
      req_valid = 1'b0;
      while (!accel_rd_en && n < 20) begin tick(); n++; end
      tests++; if (accel_rd_en !== 1'b1) begin failed++; $display("[TB] FAIL rstmid_issue: got %b expected 1", accel_rd_en); end
      tick();
      rst = 1'b1; tick(); rst = 1'b0;
      drops = 0; dropBudget = 0; clear_logs();
      accel_rd_valid = 1'b1; accel_rd_data = memLine(16'h0400);
      tests++; if ({rsp_valid, wr_ack, accel_wrt_en, accel_rd_en} !== 4'b0 || q_count !== 4'd0 || req_ready !== 1'b1) begin failed++; $display("[TB] FAIL rstmid_outputs: got flags=%b q=%0d ready=%b expected 0000/0/1", {rsp_valid, wr_ack, accel_wrt_en, accel_rd_en}, q_count, req_ready); end
      tests++; if ({retry_cnt, accel_addr, accel_wrt_data} !== 64'h0 || rsp_data !== 512'h0) begin failed++; $display("[TB] FAIL rstmid_busses: got %h expected 0", {retry_cnt, accel_addr, accel_wrt_data}); end
      repeat (6) begin tick(); if (rsp_valid || accel_rd_en || accel_wrt_en || wr_ack || q_count != 0) activity++; end
      tests++; if (activity != 0 || grantLog.size() != 0) begin failed++; $display("[TB] FAIL rstmid_stale: got activity=%0d grants=%0d expected 0/0", activity, grantLog.size()); end
      clear_logs();
   endtask

   task automatic test_same_cycle();
      dropBudget = 0; rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) push_req(1'b1, 16'(16'h0500 + i * 4), 32'($urandom()));
      req_valid = 1'b0;
      tests++; if (q_count !== 4'd3 || ackCnt != 1) begin failed++; $display("[TB] FAIL same_cycle_count: got q=%0d acks=%0d expected q=3 acks=1", q_count, ackCnt); end
      drain();
      tests++; if (orderErrors() != 0 || ackCnt != 4) begin failed++; $display("[TB] FAIL same_cycle_order: got order_err=%0d acks=%0d expected 0/4", orderErrors(), ackCnt); end
      clear_logs();
   endtask

   task automatic test_random();
      randRsp = 1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) dropBudget = int'($urandom_range(0, 3));
         rsp_ready = 1'($urandom_range(0, 1));
         push_req(1'($urandom_range(0, 1)), 16'($urandom()), 32'($urandom()));
         if ($urandom_range(0, 2) == 0) begin
            req_valid = 1'b0;
            repeat ($urandom_range(1, 4)) begin rsp_ready = 1'($urandom_range(0, 1)); tick(); end
         end
      end
      randRsp = 0;
      drain();
      tests++; if (orderErrors() != 0) begin failed++; $display("[TB] FAIL rand_order: got %0d errors expected 0", orderErrors()); end
      tests++; if (rspErrors() != 0) begin failed++; $display("[TB] FAIL rand_rsp: got %0d errors expected 0", rspErrors()); end
      tests++; if (ackCnt != writeCount()) begin failed++; $display("[TB] FAIL rand_acks: got %0d expected %0d", ackCnt, writeCount()); end
      tests++; if (retry_cnt !== 16'(drops)) begin failed++; $display("[TB] FAIL rand_retry: got %0d expected %0d", retry_cnt, drops); end
      tests++; if (protoErrs != 0 || timeouts != 0) begin failed++; $display("[TB] FAIL rand_protocol: got proto=%0d timeouts=%0d expected 0/0", protoErrs, timeouts); end
      clear_logs();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_retry();
      test_back_to_back();
      test_rsp_gate();
      test_reset_mid();
      test_same_cycle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
